// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  localparam int unsigned N_DEF    = 32;
  localparam int unsigned IDXW_DEF = $clog2(N_DEF);

  // Binary index of the set bit in a one-hot vector; all-zero maps to 0.
  function automatic logic [IDXW_DEF-1:0] onehot_to_idx(input logic [N_DEF-1:0] oh);
    logic [IDXW_DEF-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_DEF; i++) begin
      if (oh[i]) idx |= IDXW_DEF'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsb_isolate.sv
// Lowest-set-bit isolator: one-hot of the lowest set bit of in_i (bit 0 highest priority).
module lsb_isolate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in_i,
  output logic [N-1:0] onehot_o
);

  // Two's complement negate keeps only the lowest set bit when ANDed back.
  assign onehot_o = in_i & (~in_i + N'(1));

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant behind a valid/ready handshake.
// Optional macro GNT_LOCK_EN adds a lock input that holds the grant across accepts.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
`ifdef GNT_LOCK_EN
  input  logic            lock,
`endif
  input  logic            gnt_ready
);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic            accept;
  logic            lock_act;
  logic [IDXW-1:0] ptr_eff;
  logic [N-1:0]    hi_mask;
  logic [N-1:0]    masked;
  logic [N-1:0]    pick_m, pick_r, pick;
  logic [N-1:0]    pick_ext_n;
  logic [N_DEF-1:0]    pick_ext;
  logic [IDXW_DEF-1:0] pick_idx_full;
  logic [IDXW-1:0] pick_idx;

`ifdef GNT_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  assign accept  = (state_q == OFFER) && gnt_ready;
  // An accept moves the pointer this cycle, so the back-to-back pick must already see it.
  assign ptr_eff = accept ? gnt_idx_q : ptr_q;

  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      hi_mask[k] = (k > int'(ptr_eff));
    end
  end

  assign masked = req & hi_mask;

  lsb_isolate #(.N(N)) u_iso_masked (
    .in_i     (masked),
    .onehot_o (pick_m)
  );

  lsb_isolate #(.N(N)) u_iso_req (
    .in_i     (req),
    .onehot_o (pick_r)
  );

  assign pick          = (|masked) ? pick_m : pick_r;
  assign pick_ext_n    = pick;
  assign pick_ext      = N_DEF'(pick_ext_n);
  assign pick_idx_full = onehot_to_idx(pick_ext);
  assign pick_idx      = pick_idx_full[IDXW-1:0];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = pick;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (gnt_ready && !lock_act) begin
          ptr_d = gnt_idx_q;
          if (|req) begin
            gnt_d     = pick;
            gnt_idx_d = pick_idx;
          end else begin
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= IDXW'(N - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: table-driven vectors plus hand sequences, checked through a scoreboard queue.
module tb_rr_grant_arbiter;

  localparam int N    = 32;
  localparam int IDXW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic            gnt_ready = 1'b0;
`ifdef GNT_LOCK_EN
  logic            lock = 1'b0;
`endif
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
`ifdef GNT_LOCK_EN
    .lock      (lock),
`endif
    .gnt_ready (gnt_ready)
  );

  typedef struct packed {
    logic            v;
    logic [N-1:0]    g;
    logic [IDXW-1:0] i;
  } exp_t;

  typedef struct {
    logic [N-1:0]    req;
    logic            rdy;
    logic            ev;
    logic [IDXW-1:0] ei;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk_exp(input logic ev, input logic [IDXW-1:0] ei);
    exp_t e;
    logic [N-1:0] one;
    one = 1;
    e.v = ev;
    e.i = ev ? ei : '0;
    e.g = ev ? (one << ei) : '0;
    return e;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (gnt_valid !== e.v || gnt !== e.g || (e.v && gnt_idx !== e.i)) begin
        bad++;
        $display("FAIL %s: got valid=%0b gnt=%h idx=%0d, want valid=%0b gnt=%h idx=%0d",
                 name, gnt_valid, gnt, gnt_idx, e.v, e.g, e.i);
      end
    end
  endtask

  task automatic step(input string name, input logic [N-1:0] r, input logic rdy, input logic lk,
                      input logic ev, input logic [IDXW-1:0] ei);
    req       = r;
    gnt_ready = rdy;
`ifdef GNT_LOCK_EN
    lock      = lk;
`else
    if (lk) $display("note: lock requested without lock support");
`endif
    sb_q.push_back(mk_exp(ev, ei));
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
`ifdef GNT_LOCK_EN
    lock      = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (gnt !== '0 || gnt_idx !== '0 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got gnt=%h idx=%0d valid=%0b, want gnt=0 idx=0 valid=0",
               gnt, gnt_idx, gnt_valid);
    end
  endtask

  vec_t tbl[22];

  initial begin
    tbl[0]  = '{32'h0000_0005, 1'b0, 1'b1, 5'd0};
    tbl[1]  = '{32'h0000_0005, 1'b0, 1'b1, 5'd0};
    tbl[2]  = '{32'h0000_0005, 1'b0, 1'b1, 5'd0};
    tbl[3]  = '{32'h0000_0005, 1'b0, 1'b1, 5'd0};
    tbl[4]  = '{32'h0000_0005, 1'b1, 1'b1, 5'd2};
    tbl[5]  = '{32'h0000_0005, 1'b1, 1'b1, 5'd0};
    tbl[6]  = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};
    tbl[7]  = '{32'h8000_0001, 1'b0, 1'b1, 5'd31};
    tbl[8]  = '{32'h8000_0001, 1'b1, 1'b1, 5'd0};
    tbl[9]  = '{32'h8000_0001, 1'b1, 1'b1, 5'd31};
    tbl[10] = '{32'h8000_0001, 1'b1, 1'b1, 5'd0};
    tbl[11] = '{32'h8000_0001, 1'b1, 1'b1, 5'd31};
    tbl[12] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};
    tbl[13] = '{32'h0000_0010, 1'b0, 1'b1, 5'd4};
    tbl[14] = '{32'h0000_0000, 1'b0, 1'b1, 5'd4};
    tbl[15] = '{32'h0000_0000, 1'b0, 1'b1, 5'd4};
    tbl[16] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};
    tbl[17] = '{32'h0000_0003, 1'b0, 1'b1, 5'd0};
    tbl[18] = '{32'h0000_FF00, 1'b0, 1'b1, 5'd0};
    tbl[19] = '{32'h0000_FF00, 1'b1, 1'b1, 5'd8};
    tbl[20] = '{32'h0000_0100, 1'b1, 1'b1, 5'd8};
    tbl[21] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};

    do_reset();

    for (int v = 0; v < 22; v++) begin
      step($sformatf("vec%0d", v), tbl[v].req, tbl[v].rdy, 1'b0, tbl[v].ev, tbl[v].ei);
    end

    // Reset asserted while a grant is offered must drop it without a clock edge.
    step("pre_rst_offer", 32'h0000_0040, 1'b0, 1'b0, 1'b1, 5'd6);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== '0 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_drop: got gnt=%h valid=%0b, want gnt=0 valid=0", gnt, gnt_valid);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_req2", 32'h0000_0002, 1'b0, 1'b0, 1'b1, 5'd1);
    step("sole_regrant",  32'h0000_0002, 1'b1, 1'b0, 1'b1, 5'd1);
    step("drain_a",       32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);

    // Full request vector from reset pointer: 0,1,...,31 then wrap to 0.
    do_reset();
    step("wrap_first", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0);
    for (int i = 1; i <= N; i++) begin
      step($sformatf("wrap%0d", i), 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, IDXW'(i % N));
    end
    step("drain_b", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);

`ifdef GNT_LOCK_EN
    do_reset();
    step("lock_first",  32'h0000_0003, 1'b0, 1'b0, 1'b1, 5'd0);
    step("lock_hold1",  32'h0000_0003, 1'b1, 1'b1, 1'b1, 5'd0);
    step("lock_hold2",  32'h0000_0003, 1'b1, 1'b1, 1'b1, 5'd0);
    step("lock_release",32'h0000_0003, 1'b1, 1'b0, 1'b1, 5'd1);
    step("lock_no_req", 32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd1);
    step("lock_drain",  32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Wraps the team's 32-input lowest-set-bit priority isolator (one-hot, bit 0 highest) in a rotating-priority scheme.
- Presents a registered one-hot grant through a valid/ready handshake.
- Sits between per-requester request lines and the shared resource's issue port.

Parameters:
- N, 32, number of requesters (2..32).
- IDXW, $clog2(N), width of the grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector, bit k = requester k.
- gnt  out  N  registered one-hot grant; all zero when gnt_valid=0.
- gnt_idx  out  IDXW  binary index of the set bit in gnt.
- gnt_valid  out  1  a grant is being offered.
- gnt_ready  in  1  resource accepts the offered grant this cycle.
- lock  in  1  hold the grant to the same requester (present only with GNT_LOCK_EN).

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_idx=0, gnt_valid=0, ptr=N-1, state=IDLE.
- Internal ptr (IDXW bits) holds the index of the last accepted grant.
- Selection, combinational:
  - hi_mask = bits strictly above ptr; masked = req & hi_mask.
  - pick = isolate(masked) if masked != 0, else isolate(req).
  - After reset (ptr=N-1), hi_mask=0, so the first pick is plain fixed priority.
- States:
  - IDLE: gnt_valid=0. If req != 0, register pick into gnt/gnt_idx, set gnt_valid=1, go to OFFER. Latency is one cycle from req to gnt_valid.
  - OFFER, gnt_ready=0: gnt, gnt_idx and gnt_valid hold stable. req changes are ignored; the grant is sticky until accepted.
  - OFFER, gnt_ready=1 (accept): ptr<=gnt_idx. Evaluate pick using the new ptr and the same-cycle req. If req != 0, register the new pick and stay in OFFER (back-to-back, no bubble). Else clear gnt, gnt_valid=0, go to IDLE.
  - The accepted requester's own bit is eligible at lowest priority. A sole requester is re-granted every cycle.
- Wrap-around: ptr=N-1 gives an empty hi_mask and falls back to bit 0.
- Fairness: any requester holding req continuously is granted within N accepts.
- Reset mid-OFFER drops the grant immediately. No accept is reported.
- req bits at or above N do not exist; the isolator is instantiated N wide.

Optional Feature:
- Macro GNT_LOCK_EN.
- Defined:
  - The lock port exists.
  - An accept with lock=1 re-offers the same gnt/gnt_idx next cycle, regardless of req, and ptr is not updated.
  - Locked tenure ends on the first accept with lock=0, which follows normal rules.
- Undefined: the port is absent and behaviour equals lock=0 always.

Decomposition:
- Package rr_arb_pkg: state enum (IDLE, OFFER), default N/IDXW constants, onehot-to-index function.
- One sub-module, lsb_isolate: a parameterized N-bit lowest-set-bit one-hot isolator, instantiated twice (masked and unmasked).

Test Plan:
- Reset, then req=0x0000_0005: gnt=0x1, gnt_idx=0, gnt_valid=1 one cycle later. Hold gnt_ready=0 for 3 cycles: outputs stable.
- req=0x8000_0001 held, gnt_ready=1 every cycle: grants alternate 0,31,0,31 with no idle cycle.
- req=0xFFFF_FFFF held, gnt_ready=1: gnt_idx runs 0,1,…,31,0 (wrap-around verified).
- Grant offered to idx 4, then req drops to 0 while gnt_ready=0: grant stays 0x10 until ready. Accept with req=0 gives gnt_valid=0 next cycle.
- Assert rst_n=0 mid-OFFER: gnt=0 and gnt_valid=0 immediately. After release, req=0x2 is granted as idx 1.
- GNT_LOCK_EN, req=0x3: idx 0 accepted with lock=1 twice keeps gnt=0x1. Accept with lock=0 gives next grant idx 1.
